module_boot_loader: RTL and testbench

- Upstream of the single-cycle datapath; fills instruction memory before the core fetches `instr_i`.
- Accepts a framed byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word into the instruction RAM write port.
- Holds the core in reset until a frame completes with a valid checksum, then releases it.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/module_boot_loader_if.sv | 32 +++
 rtl/module_byte_packer.sv | 51 +++++
 rtl/module_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_module_boot_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/module_boot_loader_if.sv
// Byte-stream input, instruction RAM write port and status of the boot loader.
interface module_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);

  logic              boot_i;
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  // Loader side
  modport slave (
    input  boot_i, rx_data_i, rx_valid_i,
    output rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_rst_o, busy_o, done_o, error_o
  );

  // Byte source / system side
  modport master (
    output boot_i, rx_data_i, rx_valid_i,
    input  rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
           core_rst_o, busy_o, done_o, error_o
  );

endinterface

// File: rtl/module_byte_packer.sv
// Assembles four bytes (LSB first) into a 32-bit word with a one-cycle word pulse.
module module_byte_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [1:0]        lane,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [3*BYTE_W-1:0] low_q;
  logic [1:0]          lane_q;
  logic                word_valid_q;
  logic [WORD_W-1:0]   word_q;

  // Lane shifter: bytes 0..2 are held, byte 3 completes the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_q        <= '0;
      lane_q       <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear) begin
        lane_q <= '0;
        low_q  <= '0;
      end else if (byte_valid) begin
        case (lane_q)
          2'd0: low_q[7:0]   <= byte_data;
          2'd1: low_q[15:8]  <= byte_data;
          2'd2: low_q[23:16] <= byte_data;
          default: begin
            word_q       <= {byte_data, low_q};
            word_valid_q <= 1'b1;
          end
        endcase
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign lane       = lane_q;
  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/module_boot_loader.sv
// Frame parser that fills instruction RAM and holds the core in reset until a good frame.
module module_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 10,
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned       TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  module_boot_loader_if.slave  bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  chk_q, chk_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               core_rst_q, core_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               accept_c;
  logic               in_frame_c;
  logic               pack_clear_c;
  logic               pack_valid_c;
  logic [1:0]         lane;
  logic               word_valid;
  logic [WORD_W-1:0]  word;
  logic [LEN_W-1:0]   len_new_c;

  assign accept_c     = bus.rx_valid_i & ready_q;
  assign in_frame_c   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign pack_clear_c = accept_c && (state_q == ST_SYNC) && (bus.rx_data_i == SYNC_BYTE);
  assign pack_valid_c = accept_c && (state_q == ST_DATA);
  assign len_new_c    = {bus.rx_data_i, len_q[7:0]};

  module_byte_packer u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (pack_clear_c),
    .byte_valid (pack_valid_c),
    .byte_data  (bus.rx_data_i),
    .lane       (lane),
    .word_valid (word_valid),
    .word       (word)
  );

  // State, datapath and registered-output flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SYNC;
      chk_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      to_q       <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      to_q       <= to_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state, checksum/index/timeout update and next registered outputs
  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    len_d   = len_q;
    idx_d   = idx_q;
    to_d    = to_q;
    addr_d  = addr_q;

    if (in_frame_c) begin
      to_d = accept_c ? '0 : to_q + TO_W'(1);
    end

    case (state_q)
      ST_SYNC: begin
        if (accept_c && (bus.rx_data_i == SYNC_BYTE)) begin
          chk_d   = '0;
          idx_d   = '0;
          to_d    = '0;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept_c) begin
          len_d[7:0] = bus.rx_data_i;
          chk_d      = chk_q ^ bus.rx_data_i;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept_c) begin
          len_d[15:8] = bus.rx_data_i;
          chk_d       = chk_q ^ bus.rx_data_i;
          if (32'(len_new_c) > DEPTH) begin
            state_d = ST_ERROR;
          end else if (len_new_c == '0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          chk_d = chk_q ^ bus.rx_data_i;
          if (lane == 2'd3) begin
            addr_d = idx_q[ADDR_W-1:0];
            idx_d  = idx_q + IDX_W'(1);
            if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept_c) begin
          state_d = (bus.rx_data_i == chk_q) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (bus.boot_i) begin
          state_d = ST_SYNC;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // Idle gap inside a frame aborts it
    if (in_frame_c && !accept_c && (32'(to_q) == TIMEOUT_CYC - 32'd1)) begin
      state_d = ST_ERROR;
    end

    ready_d    = (state_d != ST_DONE) && (state_d != ST_ERROR);
    core_rst_d = (state_d != ST_DONE);
    busy_d     = (state_d != ST_SYNC) && (state_d != ST_DONE) && (state_d != ST_ERROR);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  assign bus.rx_ready_o   = ready_q;
  assign bus.core_rst_o   = core_rst_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.error_o      = error_q;
  assign bus.imem_we_o    = word_valid;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = word;

endmodule

// File: tb/tb_module_boot_loader.sv
// Scoreboard bench: expected RAM writes are queued by stimulus, popped by a write monitor.
module tb_module_boot_loader;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TO_CYC = 50;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wr_t  exp_q[$];
  logic [7:0] frm[$];

  module_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  module_boot_loader #(
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic crst, input logic rdy, input logic busy);
    check({tag, ".done"},     32'(bus.done_o),     32'(done));
    check({tag, ".error"},    32'(bus.error_o),    32'(err));
    check({tag, ".core_rst"}, 32'(bus.core_rst_o), 32'(crst));
    check({tag, ".ready"},    32'(bus.rx_ready_o), 32'(rdy));
    check({tag, ".busy"},     32'(bus.busy_o),     32'(busy));
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  // One byte per cycle; the loader is always ready inside a frame
  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      bus.rx_data_i  = b[i];
      bus.rx_valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic boot_pulse();
    bus.boot_i = 1'b1;
    @(posedge clk);
    #1;
    bus.boot_i = 1'b0;
  endtask

  // Write monitor: every strobe must match the oldest expected write
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (bus.imem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   bus.imem_addr_o, bus.imem_wdata_o);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(bus.imem_addr_o), 32'(w.addr));
          check("wr_data", bus.imem_wdata_o, w.data);
        end
      end
    end
  end

  // Global guard against a hung run
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  chk;
    logic [31:0] w;
    checks = 0;
    errors = 0;
    bus.boot_i     = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset values
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("reset.we",    32'(bus.imem_we_o),   32'd0);
    check("reset.addr",  32'(bus.imem_addr_o), 32'd0);
    check("reset.wdata", bus.imem_wdata_o,     32'd0);

    // Good two-word frame; checksum = 02^13^93^10 = 0x92
    push_wr(0, 32'h0000_0013);
    push_wr(1, 32'h0010_0093);
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_bytes(frm);
    check_status("frame_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    boot_pulse();
    check_status("boot_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Leading junk is dropped in SYNC
    frm = {8'h00, 8'hFF, 8'h37};
    send_bytes(frm);
    check_status("junk", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_wr(0, 32'h0000_0013);
    push_wr(1, 32'h0010_0093);
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_bytes(frm);
    check_status("frame_junk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    boot_pulse();

    // Bad checksum: words still written, then ERROR
    push_wr(0, 32'h0000_0013);
    push_wr(1, 32'h0010_0093);
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h80};
    send_bytes(frm);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    boot_pulse();
    check_status("boot_err", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Empty frame
    frm = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_bytes(frm);
    check_status("len0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    boot_pulse();

    // len 17 exceeds the 16-word RAM
    frm = {8'hA5, 8'h11, 8'h00};
    send_bytes(frm);
    check_status("len17", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    boot_pulse();

    // len 16 fills the RAM exactly; last address 15
    frm = {8'hA5, 8'h10, 8'h00};
    chk = 8'h10;
    for (int i = 0; i < 16; i++) begin
      w = {8'(i), 8'hC3, 8'(i * 7), 8'h5A};
      push_wr(i, w);
      for (int k = 0; k < 4; k++) begin
        frm.push_back(w[8*k +: 8]);
        chk = chk ^ w[8*k +: 8];
      end
    end
    frm.push_back(chk);
    send_bytes(frm);
    check_status("len16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    boot_pulse();

    // Stall after 5 payload bytes: ERROR on the 50th idle cycle
    push_wr(0, 32'h0000_0013);
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    send_bytes(frm);
    idle(TO_CYC - 1);
    check_status("stall_49", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    check_status("stall_50", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    boot_pulse();

    // Asynchronous reset mid-DATA with a byte being offered
    push_wr(0, 32'h0000_0013);
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_bytes(frm);
    bus.rx_data_i  = 8'h55;
    bus.rx_valid_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_status("async_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("async_rst.we",    32'(bus.imem_we_o),   32'd0);
    check("async_rst.addr",  32'(bus.imem_addr_o), 32'd0);
    check("async_rst.wdata", bus.imem_wdata_o,     32'd0);
    idle(2);
    bus.rx_valid_i = 1'b0;
    rst = 1'b0;
    idle(1);

    // Full frame with a 10-cycle gap and an ignored boot request
    push_wr(0, 32'h0000_0013);
    push_wr(1, 32'h0010_0093);
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_bytes(frm);
    idle(5);
    boot_pulse();
    idle(4);
    check_status("gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    frm = {8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_bytes(frm);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    idle(3);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
